// File: rtl/mult_pipe_param.sv
// Four-stage pipelined WIDTH x WIDTH multiplier with signed/unsigned mode,
// tag pass-through and valid/ready flow control driven by one global advance.
module mult_pipe_param #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_VALID,
    output logic               o_READY,
    input  logic [WIDTH-1:0]   i_OP1,
    input  logic [WIDTH-1:0]   i_OP2,
    input  logic               i_SIGNED,
    input  logic [TAG_W-1:0]   i_TAG,
    output logic               o_VALID,
    input  logic               i_READY,
    output logic [2*WIDTH-1:0] o_RESULT,
    output logic [TAG_W-1:0]   o_TAG
);

    localparam int H = WIDTH / 2;
    localparam int P = 2 * WIDTH;

    logic             adv;
    logic             v1, v2, v3, v4;
    logic             neg1, neg2, neg3;
    logic [TAG_W-1:0] tag1, tag2, tag3, tag4;

    logic [WIDTH-1:0] mag1_d, mag2_d, mag1_q, mag2_q;
    logic             neg_d;
    logic [WIDTH-1:0] pp_hh_d, pp_hl_d, pp_lh_d, pp_ll_d;
    logic [WIDTH-1:0] pp_hh_q, pp_hl_q, pp_lh_q, pp_ll_q;
    logic [P-1:0]     sum_a_d, sum_b_d, sum_a_q, sum_b_q;
    logic [P-1:0]     sum_ab, res_d, res_q;

    // A full output register with a stalled consumer freezes every stage.
    assign adv      = ~v4 | i_READY;
    assign o_READY  = adv;
    assign o_VALID  = v4;
    assign o_RESULT = res_q;
    assign o_TAG    = tag4;

    always_comb begin
        mag1_d = (i_SIGNED && i_OP1[WIDTH-1]) ? -i_OP1 : i_OP1;
        mag2_d = (i_SIGNED && i_OP2[WIDTH-1]) ? -i_OP2 : i_OP2;
        neg_d  = i_SIGNED & (i_OP1[WIDTH-1] ^ i_OP2[WIDTH-1]);
    end

    always_comb begin
        pp_hh_d = {{H{1'b0}}, mag1_q[WIDTH-1:H]} * {{H{1'b0}}, mag2_q[WIDTH-1:H]};
        pp_hl_d = {{H{1'b0}}, mag1_q[WIDTH-1:H]} * {{H{1'b0}}, mag2_q[H-1:0]};
        pp_lh_d = {{H{1'b0}}, mag1_q[H-1:0]}     * {{H{1'b0}}, mag2_q[WIDTH-1:H]};
        pp_ll_d = {{H{1'b0}}, mag1_q[H-1:0]}     * {{H{1'b0}}, mag2_q[H-1:0]};
    end

    always_comb begin
        // hi*hi << WIDTH and lo*lo never overlap, so their sum is a concatenation.
        sum_a_d = {pp_hh_q, pp_ll_q};
        sum_b_d = {{H{1'b0}}, pp_hl_q, {H{1'b0}}} + {{H{1'b0}}, pp_lh_q, {H{1'b0}}};
        sum_ab  = sum_a_q + sum_b_q;
        res_d   = neg3 ? -sum_ab : sum_ab;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            v4      <= 1'b0;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            neg3    <= 1'b0;
            tag1    <= '0;
            tag2    <= '0;
            tag3    <= '0;
            tag4    <= '0;
            mag1_q  <= '0;
            mag2_q  <= '0;
            pp_hh_q <= '0;
            pp_hl_q <= '0;
            pp_lh_q <= '0;
            pp_ll_q <= '0;
            sum_a_q <= '0;
            sum_b_q <= '0;
            res_q   <= '0;
        end else if (adv) begin
            v1      <= i_VALID;
            neg1    <= neg_d;
            tag1    <= i_TAG;
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;

            v2      <= v1;
            neg2    <= neg1;
            tag2    <= tag1;
            pp_hh_q <= pp_hh_d;
            pp_hl_q <= pp_hl_d;
            pp_lh_q <= pp_lh_d;
            pp_ll_q <= pp_ll_d;

            v3      <= v2;
            neg3    <= neg2;
            tag3    <= tag2;
            sum_a_q <= sum_a_d;
            sum_b_q <= sum_b_d;

            v4      <= v3;
            tag4    <= tag3;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_mult_pipe_param.sv
// Bench for mult_pipe_param: a 64-bit instance for directed cases and a 16-bit
// instance for a long random run, both scored against a plain-arithmetic model.
module tb_mult_pipe_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         v64, r64, s64, ordy64, ov64;
    logic [63:0]  a64, b64;
    logic [3:0]   t64, ot64;
    logic [127:0] res64;

    logic         v16, r16, s16, ordy16, ov16;
    logic [15:0]  a16, b16;
    logic         t16, ot16;
    logic [31:0]  res16;

    mult_pipe_param #(.WIDTH(64), .TAG_W(4)) u64 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(v64), .o_READY(ordy64),
        .i_OP1(a64), .i_OP2(b64), .i_SIGNED(s64), .i_TAG(t64),
        .o_VALID(ov64), .i_READY(r64), .o_RESULT(res64), .o_TAG(ot64)
    );

    mult_pipe_param #(.WIDTH(16), .TAG_W(1)) u16 (
        .i_CLK(clk), .i_RST(rst), .i_VALID(v16), .o_READY(ordy16),
        .i_OP1(a16), .i_OP2(b16), .i_SIGNED(s16), .i_TAG(t16),
        .o_VALID(ov16), .i_READY(r16), .o_RESULT(res16), .o_TAG(ot16)
    );

    typedef struct {
        logic [127:0] res;
        logic [3:0]   tag;
    } e64_t;

    typedef struct {
        logic [31:0] res;
        logic        tag;
    } e16_t;

    e64_t q64[$];
    e16_t q16[$];

    int checks = 0;
    int failures = 0;
    int acc16_cnt = 0;
    int del16_cnt = 0;

    logic [127:0] pend64;
    logic         snap_v, snap_rdy, acc64;
    logic [127:0] snap_res;
    logic [3:0]   snap_tag;

    // Reference: extend each operand to the product width by its mode, multiply.
    function automatic logic [127:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                           input logic s);
        logic [127:0] ea, eb;
        ea = s ? {{64{a[63]}}, a} : {64'b0, a};
        eb = s ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        logic [31:0] ea, eb;
        ea = s ? {{16{a[15]}}, a} : {16'b0, a};
        eb = s ? {{16{b[15]}}, b} : {16'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    function automatic logic [15:0] rand16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set64(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic [3:0] t, input logic r,
                         input logic [127:0] e);
        v64 = v; a64 = a; b64 = b; s64 = s; t64 = t; r64 = r; pend64 = e;
    endtask

    // One clock: sample and score both DUTs at the falling edge, then step past the rising edge.
    task automatic tick();
        e64_t e;
        e16_t f;
        @(negedge clk);
        snap_v   = ov64;
        snap_rdy = ordy64;
        snap_res = res64;
        snap_tag = ot64;
        acc64    = 1'b0;
        if (!rst) begin
            if (ov64 && r64) begin
                chk("u64_unexpected_result", q64.size() != 0, 1);
                if (q64.size() != 0) begin
                    e = q64.pop_front();
                    chk("u64_result", res64, e.res);
                    chk("u64_tag", ot64, e.tag);
                end
            end
            if (v64 && ordy64) begin
                e.res = pend64;
                e.tag = t64;
                q64.push_back(e);
                acc64 = 1'b1;
            end
            if (ov16 && r16) begin
                chk("u16_unexpected_result", q16.size() != 0, 1);
                if (q16.size() != 0) begin
                    f = q16.pop_front();
                    chk("u16_result", res16, f.res);
                    chk("u16_tag", ot16, f.tag);
                end
                del16_cnt++;
            end
            if (v16 && ordy16) begin
                f.res = ref16(a16, b16, s16);
                f.tag = t16;
                q16.push_back(f);
                acc16_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        v64 = 1'b0; r64 = 1'b1; v16 = 1'b0; r16 = 1'b1;
        for (int i = 0; i < 40 && (q64.size() != 0 || q16.size() != 0); i++) tick();
        chk("drain_q64_empty", q64.size(), 0);
        chk("drain_q16_empty", q16.size(), 0);
    endtask

    logic [63:0]  t2a[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                             64'h8000_0000_0000_0000, 64'd5};
    logic [63:0]  t2b[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                             64'd1, 64'hFFFF_FFFF_FFFF_FFFD};
    logic [127:0] t2s[4] = '{128'd1,
                             128'h4000_0000_0000_0000_0000_0000_0000_0000,
                             128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000,
                             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
    logic [127:0] t2u[4] = '{128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
                             128'h4000_0000_0000_0000_0000_0000_0000_0000,
                             128'h0000_0000_0000_0000_8000_0000_0000_0000,
                             128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1};

    initial begin
        logic [63:0]  ra, rb;
        logic         rs, rr, rv;
        logic [127:0] exp0;
        logic         vh[16];
        int           lat, idx;

        // Reset state
        rst = 1'b1;
        set64(1'b0, 64'h0, 64'h0, 1'b0, 4'h0, 1'b1, 128'h0);
        v16 = 1'b0; a16 = 16'h0; b16 = 16'h0; s16 = 1'b0; t16 = 1'b0; r16 = 1'b1;
        tick();
        tick();
        chk("reset_ovalid", snap_v, 0);
        chk("reset_result", snap_res, 0);
        chk("reset_tag", snap_tag, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", snap_rdy, 1);

        // Unsigned all-ones product, latency 4
        set64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd3, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        tick();
        chk("t1_accept", acc64, 1);
        v64 = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (snap_v) break;
        end
        chk("t1_latency", lat, 4);
        chk("t1_result", snap_res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        chk("t1_tag", snap_tag, 3);
        drain();

        // Signed corners with the mode flipping on every beat
        for (int i = 0; i < 8; i++) begin
            idx = i / 2;
            rs = (i % 2 == 0);
            set64(1'b1, t2a[idx], t2b[idx], rs, 4'(i), 1'b1, rs ? t2s[idx] : t2u[idx]);
            tick();
            chk("t2_accept", acc64, 1);
        end
        drain();

        // Backpressure with 8 tagged beats
        idx = 0;
        exp0 = '0;
        for (int c = 0; c < 60 && (idx < 8 || q64.size() != 0); c++) begin
            rr = (c < 4) || (c >= 10);
            if (idx < 8) begin
                ra = rand64(); rb = rand64(); rs = 1'($urandom());
                if (idx == 0) exp0 = ref64(ra, rb, rs);
                set64(1'b1, ra, rb, rs, 4'(idx), rr, ref64(ra, rb, rs));
            end else begin
                set64(1'b0, 64'h0, 64'h0, 1'b0, 4'h0, rr, 128'h0);
            end
            tick();
            if (acc64) idx++;
            if (c >= 4 && c < 10) begin
                chk("bp_valid_held", snap_v, 1);
                chk("bp_ready_low", snap_rdy, 0);
                chk("bp_hold_result", snap_res, exp0);
                chk("bp_hold_tag", snap_tag, 0);
            end
        end
        chk("bp_all_accepted", idx, 8);
        drain();

        // Bubbles: every other cycle valid
        for (int i = 0; i < 16; i++) begin
            vh[i] = (i < 8) ? (i % 2 == 0) : 1'b0;
            ra = rand64(); rb = rand64(); rs = 1'($urandom());
            set64(vh[i], ra, rb, rs, 4'(i), 1'b1, ref64(ra, rb, rs));
            tick();
            if (i >= 4) chk("bubble_ovalid", snap_v, vh[i-4]);
        end
        drain();

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            ra = rand64(); rb = rand64();
            set64(1'b1, ra, rb, 1'b1, 4'(9 + i), 1'b1, ref64(ra, rb, 1'b1));
            tick();
        end
        set64(1'b0, 64'h0, 64'h0, 1'b0, 4'h0, 1'b1, 128'h0);
        rst = 1'b1;
        tick();
        q64.delete();
        rst = 1'b0;
        tick();
        chk("flush_ovalid", snap_v, 0);
        chk("flush_result", snap_res, 0);
        chk("flush_tag", snap_tag, 0);
        chk("flush_ready", snap_rdy, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("flush_no_output", snap_v, 0);
        end

        // Random 64-bit traffic with random backpressure
        idx = 0;
        for (int c = 0; c < 4000 && idx < 300; c++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            ra = rand64(); rb = rand64(); rs = 1'($urandom());
            set64(rv, ra, rb, rs, 4'($urandom()), rr, ref64(ra, rb, rs));
            tick();
            if (acc64) idx++;
        end
        chk("rand64_accepted", idx, 300);
        drain();

        // Random 16-bit traffic, 10k beats
        set64(1'b0, 64'h0, 64'h0, 1'b0, 4'h0, 1'b1, 128'h0);
        acc16_cnt = 0;
        del16_cnt = 0;
        for (int c = 0; c < 60000 && acc16_cnt < 10000; c++) begin
            v16 = ($urandom_range(0, 3) != 0);
            r16 = ($urandom_range(0, 3) != 0);
            a16 = rand16(); b16 = rand16(); s16 = 1'($urandom()); t16 = 1'($urandom());
            tick();
        end
        chk("rand16_accepted", acc16_cnt, 10000);
        drain();
        chk("rand16_delivered", del16_cnt, 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_pipe_param.md
Name: mult_pipe_param

Overview:
Parametrised, pipelined WIDTH x WIDTH multiplier with a 2*WIDTH-bit product. It is the successor to the fixed 64-bit pipelined multiplier and adds three things: a per-transaction signed/unsigned mode, valid/ready flow control with stall, and a tag that travels alongside each operand pair. It sits between an operand-issue unit and a result consumer that may apply backpressure.

Parameters:
WIDTH, 64, operand width; must be even and >= 8; the datapath splits each operand into two halves of WIDTH/2.
TAG_W, 4, width of the user tag carried with each transaction.

Ports:
i_CLK  input  1  clock; all logic on rising edge.
i_RST  input  1  synchronous, active-high reset.
i_VALID  input  1  operand pair and mode are presented.
o_READY  output  1  pipeline can accept an input this cycle.
i_OP1  input  WIDTH  multiplicand.
i_OP2  input  WIDTH  multiplier.
i_SIGNED  input  1  1 = two's-complement operands; 0 = unsigned.
i_TAG  input  TAG_W  user tag; returned unchanged with the result.
o_VALID  output  1  o_RESULT and o_TAG hold a completed product.
i_READY  input  1  consumer accepts the result this cycle.
o_RESULT  output  2*WIDTH  product.
o_TAG  output  TAG_W  tag of the transaction on o_RESULT.

Behaviour:
- Handshake: an input is accepted on a clock edge where i_VALID && o_READY. A result is delivered on an edge where o_VALID && i_READY.
- Global advance: adv = ~o_VALID | i_READY. o_READY = adv, combinational; no combinational path from i_VALID to o_READY.
- When adv = 0, every stage register, including its valid bit, holds its value. o_RESULT and o_TAG stay stable while o_VALID = 1 and i_READY = 0.
- Four stages, each with its own valid bit; bubbles move with the data. Latency: result valid 4 cycles after acceptance when i_READY is held at 1. Throughput: 1 result per cycle.
- S1 registers:
  - the operand magnitudes; when i_SIGNED = 1 and the MSB is set, the magnitude is the two's-complement negation, taken as an unsigned WIDTH-bit value (the most negative input -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), no overflow);
  - neg = i_SIGNED & (OP1 MSB ^ OP2 MSB);
  - the tag.
- S2: registers the four WIDTH-bit partial products hi*hi, hi*lo, lo*hi, lo*lo of the halves.
- S3: registers two 2*WIDTH-bit sums:
  - lo*lo + (hi*hi << WIDTH);
  - (hi*lo << WIDTH/2) + (lo*hi << WIDTH/2).
- S4: registers the sum of the two S3 values; when neg = 1 it registers the two's-complement negation of that sum, modulo 2^(2*WIDTH).
- Arithmetic rules: all additions are 2*WIDTH bits wide and carries out of bit 2*WIDTH-1 are discarded. The result is exact because |product| <= 2^(2*WIDTH-2) in signed mode and < 2^(2*WIDTH) in unsigned mode.
- neg and the tag are pipelined alongside the data through S1..S4.
- Reset: takes effect at the clock edge with i_RST = 1, regardless of adv. All valid bits clear to 0 and all data, tag and neg registers clear to 0, so o_VALID = 0, o_RESULT = 0 and o_TAG = 0. In-flight transactions are discarded.
- During reset the o_READY value is don't-care, and inputs are ignored. The first cycle after reset deasserts has o_READY = 1.
- Simultaneous accept and deliver: when the pipeline is full and i_READY = 1, a new input is accepted on the same edge the oldest result leaves; no throughput loss.
- Back-to-back mode changes: i_SIGNED may differ on every accepted beat; each result uses its own mode.

Test Plan:
1. Unsigned, WIDTH=64, i_READY=1: OP1=0xFFFF_FFFF_FFFF_FFFF, OP2=0xFFFF_FFFF_FFFF_FFFF, tag 3 -> 4 cycles later o_VALID=1, o_RESULT=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, o_TAG=3.
2. Signed corner cases, accepted on consecutive beats:
   - -1 * -1 -> 1;
   - 0x8000_0000_0000_0000 * 0x8000_0000_0000_0000 -> 0x4000_..._0 (2^126);
   - 0x8000_0000_0000_0000 * 1 -> 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000;
   - 5 * -3 -> 2*WIDTH-bit -15.
   The same OP pattern with i_SIGNED=0 gives the unsigned products.
3. Backpressure: stream 8 beats with tags 0..7 and i_READY=0 after the first result appears. Required: o_READY goes 0 once all 4 stages are full, o_RESULT holds the tag-0 product, no beat is lost or duplicated, and results arrive in tag order after i_READY returns to 1.
4. Bubbles: alternate i_VALID 1/0 -> o_VALID alternates with a 4-cycle offset, and results match a reference model.
5. Reset mid-stream: assert i_RST for 1 cycle with 3 transactions in flight -> next cycle o_VALID=0, o_RESULT=0, and none of the flushed tags ever appear.
6. WIDTH=16, TAG_W=1: 10k random beats with random i_SIGNED and random i_READY, compared against a behavioural reference product -> zero mismatches, and output order equals input order.
